// File: rtl/serial_rx_pkg.sv
// serial_rx_pkg
// Shared definitions for the serial frame receiver:
//   rx_state_t  - receiver FSM state encoding (IDLE, DATA, PARITY, STOP)
//   START_BIT   - line level of a start bit
//   STOP_BIT    - line level of a valid stop bit
//   IDLE_LEVEL  - line level while no frame is in flight
package serial_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/rx_output_buffer.sv
// rx_output_buffer
// Holding register between the frame receiver and the downstream consumer.
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-low reset
//   load       - one-cycle strobe: a good frame completes this cycle
//   load_data  - payload of that frame
//   bad        - one-cycle strobe: a bad frame completes this cycle
//   out_ready  - downstream accepts data when high
//   data       - held payload
//   data_valid - data holds an unconsumed frame
//   frame_err  - registered copy of bad (one-cycle pulse)
//   overrun    - one-cycle pulse when a good frame is dropped
module rx_output_buffer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              bad,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data,
  output logic              data_valid,
  output logic              frame_err,
  output logic              overrun
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data       <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= bad;
      overrun   <= 1'b0;
      if (load) begin
        // A handshake in the same cycle frees the slot, so the new payload
        // replaces the consumed one and valid simply stays high.
        if (!data_valid || out_ready) begin
          data       <= load_data;
          data_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (data_valid && out_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/serial_frame_receiver.sv
// serial_frame_receiver
// Receives frames of: start bit (0), DATA_W data bits LSB first, optional
// even parity bit, stop bit (1). One bit is sampled per clock.
// Optional feature macro: SERIAL_RX_PARITY_EN (adds the PARITY state).
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-low reset
//   din        - serial bitstream, one bit per clk
//   out_ready  - downstream accepts data when high
//   data       - last accepted frame payload
//   data_valid - data holds an unconsumed frame
//   frame_err  - one-cycle pulse on bad stop bit (or bad parity)
//   overrun    - one-cycle pulse when a good frame is dropped
//   busy       - high whenever the FSM is not IDLE
module serial_frame_receiver
  import serial_rx_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data,
  output logic              data_valid,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  rx_state_t         state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shift;
  logic              frame_ok;
  logic              good_frame;
  logic              bad_frame;

`ifdef SERIAL_RX_PARITY_EN
  logic parity_bad;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shift   <= '0;
`ifdef SERIAL_RX_PARITY_EN
      parity_bad <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (din == START_BIT) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
        end
        DATA: begin
          shift[bit_cnt] <= din;
          // Counter stops at the last bit; it is cleared again on the next start.
          if (bit_cnt == LAST_BIT) begin
`ifdef SERIAL_RX_PARITY_EN
            state <= PARITY;
`else
            state <= STOP;
`endif
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
`ifdef SERIAL_RX_PARITY_EN
        PARITY: begin
          // Even parity: the parity bit must equal the XOR of the data bits.
          parity_bad <= (din != ^shift);
          state      <= STOP;
        end
`endif
        STOP: begin
          // Always return to IDLE so a start bit right after the stop bit
          // is picked up without an idle gap.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SERIAL_RX_PARITY_EN
  assign frame_ok = (din == STOP_BIT) && !parity_bad;
`else
  assign frame_ok = (din == STOP_BIT);
`endif

  // Stop bit is judged combinationally in the STOP cycle so the buffer
  // registers the outcome on the very edge that samples it.
  assign good_frame = (state == STOP) && frame_ok;
  assign bad_frame  = (state == STOP) && !frame_ok;
  assign busy       = (state != IDLE);

  rx_output_buffer #(
    .DATA_W(DATA_W)
  ) u_output_buffer (
    .clk       (clk),
    .rst       (rst),
    .load      (good_frame),
    .load_data (shift),
    .bad       (bad_frame),
    .out_ready (out_ready),
    .data      (data),
    .data_valid(data_valid),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

endmodule

// File: tb/tb_serial_frame_receiver.sv
// tb_serial_frame_receiver
// Drives whole frames bit by bit, tags each driven bit with its role in the
// frame, and predicts the outputs from frame-level rules after every edge.
module tb_serial_frame_receiver;

  localparam int DATA_W = 8;
  localparam int K_IDLE = 0, K_START = 1, K_DATA = 2, K_PAR = 3, K_STOP = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              din = 1'b1;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] data;
  logic              data_valid, frame_err, overrun, busy;

  serial_frame_receiver #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .out_ready (out_ready),
    .data      (data),
    .data_valid(data_valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ready_mode = 1;  // 0: held low, 1: held high, 2: random

  // Expected outputs
  logic [DATA_W-1:0] exp_data  = '0;
  logic              exp_valid = 1'b0;
  logic              exp_ferr  = 1'b0;
  logic              exp_ovr   = 1'b0;
  logic              exp_busy  = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, " data"},       16'(data),       16'(exp_data));
    check({tag, " data_valid"}, 16'(data_valid), 16'(exp_valid));
    check({tag, " frame_err"},  16'(frame_err),  16'(exp_ferr));
    check({tag, " overrun"},    16'(overrun),    16'(exp_ovr));
    check({tag, " busy"},       16'(busy),       16'(exp_busy));
  endtask

  // Present one bit, let one edge sample it, update the prediction, compare.
  task automatic send_bit(input logic b, input int kind, input logic good,
                          input logic [DATA_W-1:0] pl);
    @(negedge clk);
    din = b;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
    @(posedge clk);
    exp_ferr = (kind == K_STOP) && !good;
    exp_ovr  = 1'b0;
    if (kind == K_STOP && good) begin
      if (!exp_valid || out_ready) begin
        exp_data  = pl;
        exp_valid = 1'b1;
      end else begin
        exp_ovr = 1'b1;
      end
    end else if (exp_valid && out_ready) begin
      exp_valid = 1'b0;
    end
    exp_busy = (kind == K_START) || (kind == K_DATA) || (kind == K_PAR);
    #1;
    compare_all("cyc");
    $display("bit kind=%0d din=%b rdy=%b data=%h valid=%b ferr=%b ovr=%b busy=%b",
             kind, b, out_ready, data, data_valid, frame_err, overrun, busy);
  endtask

  task automatic send_idle(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1, K_IDLE, 1'b0, '0);
  endtask

  // par_flip inverts the correct even-parity bit (only meaningful with parity).
  task automatic send_frame(input logic [DATA_W-1:0] pl, input logic stop_b,
                            input logic par_flip);
    logic good;
    good = stop_b;
    send_bit(1'b0, K_START, 1'b0, pl);
    for (int i = 0; i < DATA_W; i++) send_bit(pl[i], K_DATA, 1'b0, pl);
`ifdef SERIAL_RX_PARITY_EN
    send_bit((^pl) ^ par_flip, K_PAR, 1'b0, pl);
    good = stop_b && !par_flip;
`endif
    send_bit(stop_b, K_STOP, good, pl);
    $display("frame payload=%h stop=%b flip=%b -> data=%h valid=%b ferr=%b ovr=%b",
             pl, stop_b, par_flip, data, data_valid, frame_err, overrun);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    din = 1'b1;
    #1;
    check("async rst data",  16'(data),       16'h0);
    check("async rst valid", 16'(data_valid), 16'h0);
    check("async rst busy",  16'(busy),       16'h0);
    exp_data = '0; exp_valid = 1'b0; exp_ferr = 1'b0; exp_ovr = 1'b0; exp_busy = 1'b0;
    @(posedge clk);
    #1;
    compare_all("rst");
    @(negedge clk);
    rst = 1'b1;
    $display("reset applied");
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset data",  16'(data),       16'h0);
    check("reset valid", 16'(data_valid), 16'h0);
    check("reset ferr",  16'(frame_err),  16'h0);
    check("reset ovr",   16'(overrun),    16'h0);
    check("reset busy",  16'(busy),       16'h0);
    @(negedge clk);
    rst = 1'b1;

    // Idle line for 20 cycles: nothing happens
    ready_mode = 2;
    send_idle(20);

    // 0xA5 good frame, out_ready high
    ready_mode = 1;
    send_frame(8'hA5, 1'b1, 1'b0);
    check("A5 data",  16'(data),       16'h00A5);
    check("A5 valid", 16'(data_valid), 16'h1);
    send_idle(1);
    check("A5 consumed", 16'(data_valid), 16'h0);

    // Same frame with bad stop bit
    send_frame(8'hA5, 1'b0, 1'b0);
    check("badstop ferr",  16'(frame_err),  16'h1);
    check("badstop valid", 16'(data_valid), 16'h0);
    check("badstop data",  16'(data),       16'h00A5);
    send_idle(1);
    check("badstop pulse", 16'(frame_err), 16'h0);

    // Back-to-back frames with out_ready low: second is an overrun
    ready_mode = 0;
    send_frame(8'h3C, 1'b1, 1'b0);
    send_frame(8'hC3, 1'b1, 1'b0);
    check("ovr data",  16'(data),       16'h003C);
    check("ovr valid", 16'(data_valid), 16'h1);
    check("ovr pulse", 16'(overrun),    16'h1);
    ready_mode = 1;
    send_idle(1);
    check("ovr drained", 16'(data_valid), 16'h0);
    check("ovr once",    16'(overrun),    16'h0);

    // Reset after start + 4 data bits of 0xFF, then a clean 0x5A
    send_bit(1'b0, K_START, 1'b0, 8'hFF);
    for (int i = 0; i < 4; i++) send_bit(1'b1, K_DATA, 1'b0, 8'hFF);
    do_reset();
    ready_mode = 0;
    send_frame(8'h5A, 1'b1, 1'b0);
    check("5A data",  16'(data),       16'h005A);
    check("5A valid", 16'(data_valid), 16'h1);
    check("5A ferr",  16'(frame_err),  16'h0);
    ready_mode = 1;
    send_idle(2);

`ifdef SERIAL_RX_PARITY_EN
    // 0x07 has three ones, so the even parity bit must be 1
    send_frame(8'h07, 1'b1, 1'b1);
    check("par bad ferr",  16'(frame_err),  16'h1);
    check("par bad valid", 16'(data_valid), 16'h0);
    send_frame(8'h07, 1'b1, 1'b0);
    check("par ok data",  16'(data),       16'h0007);
    check("par ok valid", 16'(data_valid), 16'h1);
    send_idle(1);
`endif

    // Randomized frames, gaps, ready patterns and occasional mid-frame reset
    for (int f = 0; f < 80; f++) begin
      logic [DATA_W-1:0] pl;
      logic stop_b, flip;
      pl         = DATA_W'($urandom);
      stop_b     = ($urandom_range(0, 9) != 0);
      flip       = ($urandom_range(0, 5) == 0);
      ready_mode = $urandom_range(0, 2);
      if ($urandom_range(0, 15) == 0) begin
        int nbits;
        nbits = $urandom_range(0, DATA_W - 1);
        send_bit(1'b0, K_START, 1'b0, pl);
        for (int i = 0; i < nbits; i++) send_bit(pl[i], K_DATA, 1'b0, pl);
        do_reset();
      end else begin
        send_frame(pl, stop_b, flip);
        send_idle($urandom_range(0, 3));
      end
    end
    ready_mode = 1;
    send_idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_frame_receiver.md
SERIAL_FRAME_RECEIVER -- requirements
Module: serial_frame_receiver

Interface
REQ-001 SHALL have parameter DATA_W, default 8, number of data bits per frame (legal 5..16).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 SHALL have port din  input  1  serial bitstream from upstream shift-register stage, one bit per clk.
REQ-005 SHALL have port out_ready  input  1  downstream accepts data when high.
REQ-006 SHALL have port data  output  DATA_W  last accepted frame payload.
REQ-007 SHALL have port data_valid  output  1  data holds an unconsumed frame.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse: bad stop bit, or bad parity when compiled in.
REQ-009 SHALL have port overrun  output  1  one-cycle pulse: good frame dropped because holding register full.
REQ-010 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-011 Frame SHALL be: start bit 0, DATA_W data bits LSB first, optional parity bit (REQ-026), stop bit 1; idle line 1.
REQ-012 States SHALL be IDLE, DATA, PARITY (only when compiled in), STOP.
REQ-013 IDLE: din=0 -> DATA with bit counter cleared; din=1 -> stay IDLE.
REQ-014 DATA: din shifted into payload position = bit counter; after bit DATA_W-1 -> PARITY if compiled in, else STOP.
REQ-015 Bit counter SHALL be $clog2(DATA_W) bits wide, never wraps inside a frame.
REQ-016 STOP: always -> IDLE next cycle; a start bit in the cycle immediately after the stop bit SHALL begin a new frame (back-to-back frames, no idle gap required).
REQ-017 Good frame (stop=1, parity ok): at the edge sampling the stop bit, data loaded and data_valid set, unless REQ-019 applies.
REQ-018 Handshake: data_valid && out_ready at an edge clears data_valid; data held stable while data_valid=1 and out_ready=0.
REQ-019 Good frame completing while data_valid=1 and out_ready=0: new payload dropped, data unchanged, overrun pulses one cycle.
REQ-020 Good frame completing in the same cycle as a handshake: new payload loaded, data_valid stays 1, no overrun.
REQ-021 Bad frame: payload discarded, frame_err pulses one cycle at the edge sampling the stop bit; data/data_valid unaffected.
REQ-022 Latency: stop bit presented in cycle N -> data_valid/frame_err/overrun visible in cycle N+1.

Reset
REQ-023 rst=0 SHALL immediately force state IDLE, counter 0, shift register 0, data 0, data_valid 0, frame_err 0, overrun 0, busy 0.
REQ-024 Reset mid-frame SHALL abort the frame; after release a fresh start bit is required.
REQ-025 First sampling edge after rst returns to 1 SHALL behave as IDLE.

Configuration
REQ-026 Macro SERIAL_RX_PARITY_EN defined: PARITY state present, one bit after data, even parity (din must equal XOR of data bits), mismatch -> frame marked bad, reported via frame_err at stop bit.
REQ-027 Macro SERIAL_RX_PARITY_EN undefined: no PARITY state, no parity logic, DATA goes straight to STOP; frame length DATA_W+2.

Structure
REQ-028 Shared package serial_rx_pkg SHALL hold state encoding (IDLE, DATA, PARITY, STOP) and constants START_BIT=0, STOP_BIT=1, IDLE_LEVEL=1.
REQ-029 Output holding register with valid/ready/overrun logic SHALL be sub-module rx_output_buffer; FSM, counter, shifter, parity stay in top.

Verification
REQ-030 DATA_W=8, no parity, out_ready=1: din 0,1,0,1,0,0,1,0,1,1 -> data=0xA5, data_valid high one cycle after stop bit, then low.
REQ-031 Same frame with stop bit 0 -> frame_err one-cycle pulse, data_valid stays 0, data unchanged.
REQ-032 out_ready=0, back-to-back frames 0x3C then 0xC3 -> data=0x3C, data_valid=1, overrun pulses once; then out_ready=1 -> data_valid clears next edge.
REQ-033 rst=0 after 4 data bits of 0xFF -> all outputs 0, busy 0; then full frame 0x5A -> data=0x5A, data_valid=1, no frame_err.
REQ-034 SERIAL_RX_PARITY_EN defined: 0x07 with parity bit 0 -> frame_err pulse; with parity bit 1 -> data=0x07 valid.
REQ-035 din held 1 for 20 cycles after reset -> busy 0, data_valid 0, frame_err 0, overrun 0 throughout.
